// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control: state encoding,
// opcode patterns/masks, instruction classes and ALU operation codes.
package legv8_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_WB_LD   = 4'd6,
    S_MEM_WR  = 4'd7,
    S_CBZ_EXE = 4'd8,
    S_B_EXE   = 4'd9,
    S_TRAP    = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_LD, CL_ST, CL_CBZ, CL_B, CL_ILLEGAL
  } op_class_t;

  localparam logic [10:0] OP_B      = 11'b00010100000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] OP_CBZ    = 11'b10110100000;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;
  localparam logic [10:0] MASK_FULL = 11'b11111111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASS  = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic op_match(logic [10:0] op, logic [10:0] pat, logic [10:0] mask);
    return (op & mask) == pat;
  endfunction

endpackage

// File: rtl/legv8_mc_ctrl_if.sv
// Shared instruction/data memory request port: controller issues strobes,
// memory answers with a single-cycle ready.
interface legv8_mc_ctrl_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
  modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/legv8_op_class.sv
// Combinational opcode decoder: maps the 11-bit IR opcode field to the
// instruction class that drives the sequencer's path through its states.
module legv8_op_class
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  always_comb begin
    op_class = CL_ILLEGAL;
    if (op_match(opcode, OP_B, MASK_B))
      op_class = CL_B;
    else if (op_match(opcode, OP_CBZ, MASK_CBZ))
      op_class = CL_CBZ;
    else if (op_match(opcode, OP_LDUR, MASK_FULL))
      op_class = CL_LD;
    else if (op_match(opcode, OP_STUR, MASK_FULL))
      op_class = CL_ST;
    else if (op_match(opcode, OP_ADD, MASK_FULL) || op_match(opcode, OP_SUB, MASK_FULL) ||
             op_match(opcode, OP_AND, MASK_FULL) || op_match(opcode, OP_ORR, MASK_FULL))
      op_class = CL_R;
  end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// Multi-cycle LEGv8 sequencer: one state per datapath step, memory handshake,
// sticky trap on unsupported opcodes and a wrapping retired-instruction count.
module legv8_mc_ctrl
  import legv8_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           opcode,
  input  logic                  zero,
  legv8_mc_ctrl_if.master       mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  tgt_write,
  output logic                  pc_src,
  output logic                  reg2loc,
  output logic                  alu_src,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic [1:0]            alu_op,
  output logic                  illegal,
  output logic [RETIRE_W-1:0]   retired,
  output logic [3:0]            state
);

  state_t    state_q, state_d;
  op_class_t cls, cls_q;
  logic      retire;

  legv8_op_class u_op_class (
    .opcode   (opcode),
    .op_class (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire)
        retired <= retired + RETIRE_W'(1);
    end
  end

  // Class is captured in DECODE so ADDR can pick load vs store after the IR moves on.
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE)
      cls_q <= cls;
  end

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.i_or_d    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    tgt_write     = 1'b0;
    pc_src        = 1'b0;
    reg2loc       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_op        = ALU_ADD;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.mem_read = 1'b1;
        ir_write     = mem.mem_ready;
        pc_write     = mem.mem_ready;
        if (mem.mem_ready)
          state_d = S_DECODE;
      end
      S_DECODE: begin
        tgt_write = 1'b1;
        case (cls)
          CL_R:         state_d = S_EXEC_R;
          CL_LD, CL_ST: state_d = S_ADDR;
          CL_CBZ:       state_d = S_CBZ_EXE;
          CL_B:         state_d = S_B_EXE;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_op  = ALU_FUNCT;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        alu_op    = ALU_FUNCT;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        reg2loc = (cls_q == CL_ST);
        state_d = (cls_q == CL_ST) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem.mem_read = 1'b1;
        mem.i_or_d   = 1'b1;
        alu_src      = 1'b1;
        if (mem.mem_ready)
          state_d = S_WB_LD;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem.mem_write = 1'b1;
        mem.i_or_d    = 1'b1;
        alu_src       = 1'b1;
        reg2loc       = 1'b1;
        if (mem.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_CBZ_EXE: begin
        alu_op   = ALU_PASS;
        pc_write = zero;
        pc_src   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_B_EXE: begin
        pc_write = 1'b1;
        pc_src   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/legv8_mc_ctrl.md
# legv8_mc_ctrl

Multi-cycle sequencer for the LEGv8 datapath, replacing single-cycle decode with a per-instruction state machine. Decodes the 11-bit opcode field held in the instruction register and issues one set of datapath controls per state. Handshakes with a shared instruction/data memory port, traps on unsupported opcodes and counts retired instructions. Sits between the instruction register and the register file, ALU, PC and memory-interface muxes.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 11: instruction bits [31:21] from the IR. Valid from DECODE onward.
- `zero` in 1: ALU zero flag. Sampled in CBZ_EXE.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_read`, `mem_write` out 1: memory request strobes. Held until `mem_ready`.
- `i_or_d` out 1: memory address source. 0 = PC, 1 = ALU result.
- `ir_write`, `pc_write`, `tgt_write` out 1: IR load, PC load, branch-target register load.
- `pc_src` out 1: PC source. 0 = PC+4, 1 = branch target.
- `reg2loc`, `alu_src`, `mem_to_reg`, `reg_write` out 1: same meanings as in the single-cycle control.
- `alu_op` out 2: 00 = add, 01 = pass/compare-zero, 10 = funct-decoded.
- `illegal` out 1: sticky trap flag.
- `retired` out RETIRE_W: count of completed instructions. Wraps.
- `state` out 4: current state encoding, for debug.

## Operation
- States: FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LD, MEM_WR, CBZ_EXE, B_EXE, TRAP.
- All outputs not listed for a state are 0. `pc_src` is 0 unless stated.
- FETCH
  - Asserts `mem_read=1`, `i_or_d=0`.
  - If `mem_ready` is 0: stay in FETCH.
  - If `mem_ready` is 1: assert `ir_write=1` and `pc_write=1` (PC+4), then go to DECODE.
- DECODE
  - Asserts `tgt_write=1`, `alu_op=00`.
  - Next state by opcode:
    - 000101xxxxx → B_EXE.
    - 10110100xxx → CBZ_EXE.
    - 11111000010 → ADDR (load).
    - 11111000000 → ADDR (store).
    - 10001011000, 11001011000, 10001010000, 10101010000 → EXEC_R.
    - Any other opcode → TRAP.
  - The opcode class is latched internally in DECODE; ADDR uses the latched class.
- EXEC_R: `alu_op=10`. Next: WB_R.
- WB_R: `reg_write=1`, `alu_op=10`. Retire. Next: FETCH.
- ADDR: `alu_src=1`, `alu_op=00`; `reg2loc=1` for a store. Next: MEM_RD for a load, MEM_WR for a store.
- MEM_RD: `mem_read=1`, `i_or_d=1`, `alu_src=1`. Leaves for WB_LD when `mem_ready` is 1.
- WB_LD: `reg_write=1`, `mem_to_reg=1`. Retire. Next: FETCH.
- MEM_WR: `mem_write=1`, `i_or_d=1`, `alu_src=1`, `reg2loc=1`. On `mem_ready`: retire, then FETCH.
- CBZ_EXE: `alu_op=01`; `pc_write=zero`, `pc_src=1`. Retire. Next: FETCH.
- B_EXE: `pc_write=1`, `pc_src=1`. Retire. Next: FETCH.
- TRAP: `illegal=1`. All strobes 0. Absorbing; only `reset` exits.
- Retire means `retired` increments by 1 on the clock edge ending that state. It wraps from all-ones to 0.

## Timing
- Reset
  - State becomes FETCH, `retired=0`, `illegal=0`.
  - Every output is decoded from state, so all outputs are 0 during reset except FETCH's `mem_read=1`.
- Reset asserted mid-instruction aborts it. Any pending memory request is dropped the next cycle, with no retire.
- Outputs are Moore-decoded from registered state. The exceptions are `ir_write`/`pc_write` in FETCH and `pc_write` in CBZ_EXE, which are gated by `mem_ready`/`zero` in the same cycle.
- Minimum cycle counts with zero-wait memory (`mem_ready` held at 1):
  - R-type: 4 (FETCH, DECODE, EXEC_R, WB_R).
  - LDUR: 5.
  - STUR: 4.
  - CBZ: 3.
  - B: 3.
- Each cycle of `mem_ready=0` adds exactly one cycle in FETCH, MEM_RD or MEM_WR.
- `mem_read` and `mem_write` are never asserted together. A request stays asserted, with the same `i_or_d`, until accepted.

## Structure
- Shared package `legv8_pkg` holds:
  - The state enum.
  - Opcode constants and masks (B, CBZ, LDUR, STUR, ADD, SUB, AND, ORR).
  - `alu_op` encodings.
- Sub-module `legv8_op_class` is a combinational opcode → class decoder {R, LD, ST, CBZ, B, ILLEGAL}. The FSM instantiates it and latches its output in DECODE.

## Test plan
- **ADD, zero-wait.** Reset, `mem_ready=1`, `opcode=10001011000`. Expect states FETCH, DECODE, EXEC_R, WB_R, FETCH; `reg_write=1` only in WB_R; `retired` goes 0→1 after 4 cycles.
- **LDUR with memory stalls.** `opcode=11111000010`, `mem_ready` low for 2 cycles in MEM_RD. Expect `mem_read=1` with `i_or_d=1` held for 3 cycles, then WB_LD with `mem_to_reg=1` and `reg_write=1`; 7 cycles total.
- **CBZ taken and not taken.** `opcode=10110100000`. With `zero=1`: `pc_write=1`, `pc_src=1` in CBZ_EXE. With `zero=0`: `pc_write=0`. Both cases retire after 3 cycles.
- **STUR then B back-to-back.** Expect `reg2loc=1` in ADDR and MEM_WR, `reg_write` never asserted, then a B_EXE pulse; `retired=2` after 7 cycles.
- **Illegal opcode.** `opcode=00000000000` reaches TRAP; `illegal` stays 1 and all strobes stay 0 for 10 cycles. Assert `reset`: expect FETCH and `illegal=0`.
- **Reset mid-operation and counter wrap.**
  - Assert `reset` during MEM_WR: expect FETCH, `mem_write=0`, no retire.
  - Run with RETIRE_W=4 for 16 B instructions: `retired` wraps to 0.
